permute_sched: RTL and testbench

Sequencer that owns the NUMSTAGES×NUMSTAGES `permute` matrix unit and presents it to the vector pipeline as a command/stream engine. It accepts one permute command (row-op or column-op plus per-row and per-column select vectors), streams NUMSTAGES input rows into the unit, fires the shuffle, then drains NUMSTAGES result rows under valid/ready back-pressure. Exactly one command is in flight at a time; the block sits between the lane-shuffle issue logic and the permute datapath.

---
 rtl/permute_pkg.sv | 28 ++
 rtl/permute_sched_perf.sv | 22 ++
 rtl/permute_sched.sv | 141 ++++++++++++++
 tb/tb_permute_sched.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/permute_pkg.sv
// permute_pkg: shared sequencer state encoding, op encodings and select helpers
// for the permute scheduler and its bench.
package permute_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHUF  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  localparam logic OP_COL = 1'b0;
  localparam logic OP_ROW = 1'b1;

  localparam int DEF_NUMSTAGES    = 8;
  localparam int DEF_LOGNUMSTAGES = 3;

  // Lane i selects i, packed lane 0 at the LSBs.
  function automatic logic [DEF_NUMSTAGES*DEF_LOGNUMSTAGES-1:0] identity_sel();
    logic [DEF_NUMSTAGES*DEF_LOGNUMSTAGES-1:0] sel;
    sel = '0;
    for (int i = 0; i < DEF_NUMSTAGES; i++) begin
      sel[i*DEF_LOGNUMSTAGES +: DEF_LOGNUMSTAGES] = DEF_LOGNUMSTAGES'(i);
    end
    return sel;
  endfunction

endpackage

// File: rtl/permute_sched_perf.sv
// permute_sched_perf: wrapping 32-bit counters of completed ops and stalled
// load/drain cycles for the permute scheduler.
module permute_sched_perf (
  input  logic        clk,
  input  logic        resetn,
  input  logic        op_done,
  input  logic        stall,
  output logic [31:0] op_count,
  output logic [31:0] stall_count
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_count    <= '0;
      stall_count <= '0;
    end else begin
      if (op_done) op_count <= op_count + 32'd1;
      if (stall)   stall_count <= stall_count + 32'd1;
    end
  end

endmodule

// File: rtl/permute_sched.sv
// permute_sched: one-command-at-a-time sequencer for the NxN permute unit:
// load N rows, wait SHUF_LAT cycles, drain N rows. Counters: PERMUTE_SCHED_PERF_EN.
module permute_sched
  import permute_pkg::*;
#(
  parameter int WIDTH        = 16,
  parameter int NUMSTAGES    = 8,
  parameter int LOGNUMSTAGES = $clog2(NUMSTAGES),
  parameter int SHUF_LAT     = 2,
  parameter int TAGW         = 4
) (
  input  logic                              clk,
  input  logic                              resetn,
  input  logic                              cmd_valid,
  output logic                              cmd_ready,
  input  logic                              cmd_op,
  input  logic [NUMSTAGES*LOGNUMSTAGES-1:0] cmd_row_num,
  input  logic [NUMSTAGES*LOGNUMSTAGES-1:0] cmd_col_num,
  input  logic [TAGW-1:0]                   cmd_tag,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [NUMSTAGES*WIDTH-1:0]        in_data,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [NUMSTAGES*WIDTH-1:0]        out_data,
  output logic                              out_last,
  output logic [TAGW-1:0]                   out_tag,
  output logic                              perm_en,
  output logic                              perm_read,
  output logic                              perm_rw_col_op,
  output logic [NUMSTAGES*LOGNUMSTAGES-1:0] perm_row_num,
  output logic [NUMSTAGES*LOGNUMSTAGES-1:0] perm_col_num,
  output logic [NUMSTAGES*WIDTH-1:0]        perm_a,
  input  logic [NUMSTAGES*WIDTH-1:0]        perm_out,
  input  logic                              perm_busy,
  output logic                              idle,
  output logic [31:0]                       op_count,
  output logic [31:0]                       stall_count
);

  localparam int SELW = NUMSTAGES * LOGNUMSTAGES;
  localparam logic [LOGNUMSTAGES:0] LAST_ROW = (LOGNUMSTAGES+1)'(NUMSTAGES - 1);
  localparam logic [2:0] SHUF_END = 3'(SHUF_LAT - 1);

  state_t                state_reg;
  logic [LOGNUMSTAGES:0] cnt_reg;
  logic [2:0]            timer_reg;
  logic                  op_reg;
  logic [SELW-1:0]       row_sel_reg;
  logic [SELW-1:0]       col_sel_reg;
  logic [TAGW-1:0]       tag_reg;
  logic                  is_last;

  assign is_last = (cnt_reg == LAST_ROW);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      timer_reg   <= '0;
      op_reg      <= OP_COL;
      row_sel_reg <= '0;
      col_sel_reg <= '0;
      tag_reg     <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (cmd_valid && !perm_busy) begin
            op_reg      <= cmd_op;
            row_sel_reg <= cmd_row_num;
            col_sel_reg <= cmd_col_num;
            tag_reg     <= cmd_tag;
            cnt_reg     <= '0;
            state_reg   <= LOAD;
          end
        end
        LOAD: begin
          if (in_valid) begin
            cnt_reg <= cnt_reg + 1'b1;
            if (is_last) begin
              timer_reg <= '0;
              state_reg <= SHUF;
            end
          end
        end
        SHUF: begin
          if (timer_reg == SHUF_END) begin
            cnt_reg   <= '0;
            state_reg <= DRAIN;
          end else begin
            timer_reg <= timer_reg + 3'd1;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (is_last) state_reg <= IDLE;
            else         cnt_reg   <= cnt_reg + 1'b1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // The reset gate keeps cmd_ready/idle low while resetn is held, even though state reads IDLE.
  assign cmd_ready = resetn && (state_reg == IDLE) && !perm_busy;
  assign idle      = resetn && (state_reg == IDLE) && !cmd_valid;
  assign in_ready  = (state_reg == LOAD);
  assign out_valid = (state_reg == DRAIN);
  assign perm_en   = in_ready && in_valid;
  assign perm_read = out_valid && out_ready;
  assign out_last  = out_valid && is_last;
  assign out_tag   = out_valid ? tag_reg : '0;

  assign perm_rw_col_op = op_reg;
  assign perm_row_num   = row_sel_reg;
  assign perm_col_num   = col_sel_reg;

  for (genvar gi = 0; gi < NUMSTAGES; gi++) begin : g_lane
    assign perm_a[gi*WIDTH +: WIDTH]   = in_ready  ? in_data[gi*WIDTH +: WIDTH]  : '0;
    assign out_data[gi*WIDTH +: WIDTH] = out_valid ? perm_out[gi*WIDTH +: WIDTH] : '0;
  end

`ifdef PERMUTE_SCHED_PERF_EN
  logic perf_stall;
  assign perf_stall = ((state_reg == LOAD) && !in_valid) || ((state_reg == DRAIN) && !out_ready);

  permute_sched_perf u_perf (
    .clk         (clk),
    .resetn      (resetn),
    .op_done     (perm_read && is_last),
    .stall       (perf_stall),
    .op_count    (op_count),
    .stall_count (stall_count)
  );
`else
  assign op_count    = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_permute_sched.sv
// tb_permute_sched: table-driven ops against a behavioural permute unit, plus
// reset, busy, held-command and mid-drain reset sequences.
module tb_permute_sched;
  import permute_pkg::*;

  localparam int W = 16, NS = 8, L = 3, TW = 4, SHUF_LAT = 2;
`ifdef PERMUTE_SCHED_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic clk, resetn;
  logic cmd_valid, cmd_ready, cmd_op;
  logic [NS*L-1:0] cmd_row_num, cmd_col_num;
  logic [TW-1:0] cmd_tag;
  logic in_valid, in_ready;
  logic [NS*W-1:0] in_data;
  logic out_valid, out_ready, out_last;
  logic [NS*W-1:0] out_data;
  logic [TW-1:0] out_tag;
  logic perm_en, perm_read, perm_rw_col_op;
  logic [NS*L-1:0] perm_row_num, perm_col_num;
  logic [NS*W-1:0] perm_a, perm_out;
  logic perm_busy, idle;
  logic [31:0] op_count, stall_count;

  permute_sched #(.WIDTH(W), .NUMSTAGES(NS), .LOGNUMSTAGES(L), .SHUF_LAT(SHUF_LAT), .TAGW(TW)) dut (
    .clk(clk), .resetn(resetn), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row_num(cmd_row_num), .cmd_col_num(cmd_col_num), .cmd_tag(cmd_tag),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last), .out_tag(out_tag),
    .perm_en(perm_en), .perm_read(perm_read), .perm_rw_col_op(perm_rw_col_op),
    .perm_row_num(perm_row_num), .perm_col_num(perm_col_num), .perm_a(perm_a),
    .perm_out(perm_out), .perm_busy(perm_busy), .idle(idle),
    .op_count(op_count), .stall_count(stall_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural permute unit: captures rows on perm_en, presents permuted rows indexed by reads.
  logic [W-1:0] mem [NS][NS];
  logic [2:0] wr_ptr, rd_ptr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (perm_en) begin
        for (int j = 0; j < NS; j++) mem[wr_ptr][j] <= perm_a[j*W +: W];
        wr_ptr <= wr_ptr + 3'd1;
      end
      if (perm_read) rd_ptr <= rd_ptr + 3'd1;
    end
  end

  always_comb begin
    perm_out = '0;
    for (int j = 0; j < NS; j++) begin
      if (perm_rw_col_op == OP_ROW) perm_out[j*W +: W] = mem[perm_row_num[rd_ptr*L +: L]][j];
      else                          perm_out[j*W +: W] = mem[rd_ptr][perm_col_num[j*L +: L]];
    end
  end

  typedef struct {
    logic            op;
    logic [NS*L-1:0] row_sel;
    logic [NS*L-1:0] col_sel;
    logic [TW-1:0]   tag;
    logic [7:0]      gaps;    // bit k: one idle in_valid cycle before load beat k
    logic [7:0]      stalls;  // bit k: one out_ready=0 cycle on drain beat k
    int              exp_ret; // cycle (accept = 0) at which cmd_ready returns
  } vec_t;

  vec_t tbl[4];
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] row_val(input int i, input int k, input int j);
    return {4'(i), 4'(k), 4'(j), 4'hA};
  endfunction

  function automatic logic [NS*W-1:0] row_data(input int i, input int k);
    logic [NS*W-1:0] r;
    for (int j = 0; j < NS; j++) r[j*W +: W] = row_val(i, k, j);
    return r;
  endfunction

  function automatic logic [NS*W-1:0] exp_row(input int i, input int r);
    logic [NS*W-1:0] res;
    for (int j = 0; j < NS; j++) begin
      if (tbl[i].op == OP_ROW) res[j*W +: W] = row_val(i, int'(tbl[i].row_sel[r*L +: L]), j);
      else                     res[j*W +: W] = row_val(i, r, int'(tbl[i].col_sel[j*L +: L]));
    end
    return res;
  endfunction

  task automatic chk_zero(input string name);
    chk({name, " handshakes"}, {cmd_ready, idle, in_ready, out_valid, perm_en, perm_read, out_last}, '0);
    chk({name, " out_tag"}, out_tag, '0);
    chk({name, " out_data"}, out_data, '0);
    chk({name, " perm_a"}, perm_a, '0);
    chk({name, " selects"}, {perm_rw_col_op, perm_row_num, perm_col_num}, '0);
    chk({name, " counters"}, {op_count, stall_count}, '0);
  endtask

  task automatic run_op(input int i, input bit hold, input bit expect_now, input int abort_beat);
    vec_t v;
    int w, cyc, beat_in, beat_out, drain_start, timing_bad, sel_bad, stab_bad, en_cnt, rd_cnt;
    bit acc, done, aborted, prev_hold;
    logic [NS*W-1:0] prev_data;
    logic [7:0] gap_taken, stall_taken;
    v = tbl[i];
    cmd_op = v.op; cmd_row_num = v.row_sel; cmd_col_num = v.col_sel; cmd_tag = v.tag;
    cmd_valid = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    acc = 1'b0;
    for (w = 0; w < 50; w++) begin
      @(negedge clk);
      acc = cmd_ready;
      @(posedge clk); #1;
      if (acc) break;
    end
    chk($sformatf("op%0d accept", i), acc, 1'b1);
    if (!acc) begin
      cmd_valid = 1'b0;
      return;
    end
    if (expect_now) chk($sformatf("op%0d held cmd accepted at once", i), w, 0);
    if (hold) begin
      cmd_op = tbl[i+1].op; cmd_row_num = tbl[i+1].row_sel;
      cmd_col_num = tbl[i+1].col_sel; cmd_tag = tbl[i+1].tag;
    end else begin
      cmd_valid = 1'b0;
    end
    cyc = 1; beat_in = 0; beat_out = 0; drain_start = 0;
    timing_bad = 0; sel_bad = 0; stab_bad = 0; en_cnt = 0; rd_cnt = 0;
    done = 1'b0; aborted = 1'b0; prev_hold = 1'b0; prev_data = '0;
    gap_taken = '0; stall_taken = '0;
    while (!done && cyc < 300) begin
      if (abort_beat >= 0 && drain_start > 0 && cyc >= drain_start && beat_out == abort_beat) begin
        resetn = 1'b0;
        #1;
        chk_zero("mid-drain reset");
        aborted = 1'b1;
        break;
      end
      if (beat_in < NS) begin
        if (v.gaps[beat_in] && !gap_taken[beat_in]) begin
          in_valid = 1'b0;
          gap_taken[beat_in] = 1'b1;
        end else begin
          in_valid = 1'b1;
          in_data = row_data(i, beat_in);
        end
      end else begin
        in_valid = 1'b1;
        in_data = {NS{16'hDEAD}};
      end
      if (drain_start > 0 && cyc >= drain_start && beat_out < NS && v.stalls[beat_out] && !stall_taken[beat_out]) begin
        out_ready = 1'b0;
        stall_taken[beat_out] = 1'b1;
      end else begin
        out_ready = 1'b1;
      end
      @(negedge clk);
      if (in_ready !== (beat_in < NS)) timing_bad++;
      if (out_valid !== (drain_start > 0 && cyc >= drain_start && beat_out < NS)) timing_bad++;
      if (cmd_ready !== 1'b0) timing_bad++;
      if ({perm_rw_col_op, perm_row_num, perm_col_num} !== {v.op, v.row_sel, v.col_sel}) sel_bad++;
      if (perm_en) en_cnt++;
      if (perm_read) rd_cnt++;
      if (prev_hold && out_data !== prev_data) stab_bad++;
      prev_hold = out_valid && !out_ready;
      prev_data = out_data;
      if (in_valid && in_ready) begin
        beat_in++;
        if (beat_in == NS) drain_start = cyc + SHUF_LAT + 1;
      end
      if (out_valid && out_ready) begin
        chk($sformatf("op%0d beat%0d {last,tag,data}", i, beat_out), {out_last, out_tag, out_data},
            {(beat_out == NS-1), v.tag, exp_row(i, beat_out)});
        beat_out++;
        if (beat_out == NS) done = 1'b1;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    if (aborted) begin
      @(posedge clk); #1;
      resetn = 1'b1;
      $display("op %0d tag %h aborted by reset at drain beat %0d", i, v.tag, abort_beat);
      return;
    end
    chk($sformatf("op%0d completed", i), done, 1'b1);
    chk($sformatf("op%0d handshake timing errors", i), timing_bad, 0);
    chk($sformatf("op%0d select changes", i), sel_bad, 0);
    chk($sformatf("op%0d stalled out_data changes", i), stab_bad, 0);
    chk($sformatf("op%0d perm_en count", i), en_cnt, NS);
    chk($sformatf("op%0d perm_read count", i), rd_cnt, NS);
    chk($sformatf("op%0d cmd_ready return cycle", i), cyc, v.exp_ret);
    if (!hold) begin
      @(negedge clk);
      chk($sformatf("op%0d back to idle {cmd_ready,idle}", i), {cmd_ready, idle}, 2'b11);
      @(posedge clk); #1;
    end
    $display("op %0d tag %h op=%0b done, cmd_ready back at cycle %0d", i, v.tag, v.op, cyc);
  endtask

  initial begin
    int busy_bad;
    tbl[0] = '{op: OP_ROW, row_sel: identity_sel(), col_sel: identity_sel(), tag: 4'h5,
               gaps: 8'h00, stalls: 8'h00, exp_ret: 19};
    tbl[1] = '{op: OP_COL, row_sel: identity_sel(), col_sel: 24'o01234567, tag: 4'hA,
               gaps: 8'h00, stalls: 8'h00, exp_ret: 19};
    tbl[2] = '{op: OP_ROW, row_sel: 24'o01234567, col_sel: identity_sel(), tag: 4'h3,
               gaps: 8'b0010_0101, stalls: 8'b1000_0010, exp_ret: 24};
    tbl[3] = '{op: OP_COL, row_sel: 24'o76543210, col_sel: 24'o22222222, tag: 4'hF,
               gaps: 8'b0000_0001, stalls: 8'b0001_0000, exp_ret: 21};

    resetn = 1'b0; perm_busy = 1'b0;
    cmd_valid = 1'b1; cmd_op = OP_ROW; cmd_row_num = identity_sel(); cmd_col_num = identity_sel(); cmd_tag = 4'h9;
    in_valid = 1'b1; in_data = {NS{16'h1234}}; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("in reset");
    @(posedge clk); #1;
    cmd_valid = 1'b0; in_valid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    chk("cmd_ready after reset release", cmd_ready, 1'b1);
    chk("idle after reset release", idle, 1'b1);
    @(posedge clk); #1;

    // perm_busy in IDLE must block acceptance.
    perm_busy = 1'b1; cmd_valid = 1'b1; busy_bad = 0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (cmd_ready !== 1'b0 || in_ready !== 1'b0) busy_bad++;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0; perm_busy = 1'b0;
    @(negedge clk);
    if (in_ready !== 1'b0) busy_bad++;
    chk("perm_busy blocks accept", busy_bad, 0);
    @(posedge clk); #1;

    for (int i = 0; i < 4; i++) run_op(i, (i == 0), (i == 1), -1);
    chk("perf after table {op,stall}", {op_count, stall_count}, PERF ? {32'd4, 32'd7} : 64'd0);

    run_op(0, 1'b0, 1'b0, 3);
    @(negedge clk);
    chk("cmd_ready after mid-drain reset", cmd_ready, 1'b1);
    @(posedge clk); #1;

    run_op(2, 1'b0, 1'b0, -1);
    run_op(0, 1'b0, 1'b0, -1);
    run_op(1, 1'b0, 1'b0, -1);
    chk("perf three ops {op,stall}", {op_count, stall_count}, PERF ? {32'd3, 32'd5} : 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
